// File: rtl/e203_exu_bjp_resolver_pkg.sv
// Shared definitions for the EXU branch/jump resolver: state encodings,
// default widths, PC increment constants and small decode helpers.
package e203_exu_bjp_resolver_pkg;

  localparam int unsigned E203_PC_SIZE = 32;
  localparam int unsigned CNT_W_DEF    = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [2:0] PC_INC_RVC  = 3'd2;
  localparam logic [2:0] PC_INC_RV32 = 3'd4;

  typedef struct packed {
    logic bjp;
    logic bxx;
    logic prdt_taken;
    logic rslv_taken;
  } bjp_info_t;

  // Only conditional branches can mispredict; jal/jalr are resolved before fetch continues.
  function automatic logic is_mispred(bjp_info_t info);
    return info.bjp & info.bxx & (info.prdt_taken ^ info.rslv_taken);
  endfunction

  function automatic logic [2:0] pc_inc(logic rv32);
    return rv32 ? PC_INC_RV32 : PC_INC_RVC;
  endfunction

endpackage

// File: rtl/e203_exu_bjp_resolver_if.sv
// Commit-beat and IFU flush handshake bundle for the branch/jump resolver.
interface e203_exu_bjp_resolver_if #(
  parameter int unsigned PC_W = 32
);

  logic            cmt_i_valid;
  logic            cmt_i_ready;
  logic            cmt_i_bjp;
  logic            cmt_i_bxx;
  logic            cmt_i_prdt_taken;
  logic            cmt_i_rslv_taken;
  logic            cmt_i_rv32;
  logic [PC_W-1:0] cmt_i_pc;
  logic [PC_W-1:0] cmt_i_imm;

  logic            flush_req;
  logic            flush_ack;
  logic [PC_W-1:0] flush_add_op1;
  logic [PC_W-1:0] flush_add_op2;

  // Resolver side
  modport slave (
    input  cmt_i_valid, cmt_i_bjp, cmt_i_bxx, cmt_i_prdt_taken, cmt_i_rslv_taken,
           cmt_i_rv32, cmt_i_pc, cmt_i_imm, flush_ack,
    output cmt_i_ready, flush_req, flush_add_op1, flush_add_op2
  );

  // Commit stage / IFU side
  modport master (
    output cmt_i_valid, cmt_i_bjp, cmt_i_bxx, cmt_i_prdt_taken, cmt_i_rslv_taken,
           cmt_i_rv32, cmt_i_pc, cmt_i_imm, flush_ack,
    input  cmt_i_ready, flush_req, flush_add_op1, flush_add_op2
  );

endinterface

// File: rtl/e203_exu_bjp_resolver_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module e203_exu_sat_cnt
  import e203_exu_bjp_resolver_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, stick at all-ones, return to zero on reset or clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/e203_exu_bjp_resolver.sv
// EXU branch/jump resolver: compares IFU prediction with resolved outcome at
// commit, raises a held flush request with next-PC operands on a mispredict,
// and keeps saturating branch/mispredict statistics.
//
//   state | meaning
//   IDLE  | accepting commits, no flush outstanding
//   REQ   | flush_req high with captured operands, commits stalled until ack
module e203_exu_bjp_resolver
  import e203_exu_bjp_resolver_pkg::*;
#(
  parameter int unsigned PC_W  = E203_PC_SIZE,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  e203_exu_bjp_resolver_if.slave     bus,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           bjp_cnt,
  output logic [CNT_W-1:0]           mispred_cnt
);

  logic [0:0]      state_q;
  logic [PC_W-1:0] op1_q;
  logic [PC_W-1:0] op2_q;
  logic            beat_acc;
  logic            beat_mis;
  bjp_info_t       info;
  logic [PC_W-1:0] seq_op2;

  assign info.bjp        = bus.cmt_i_bjp;
  assign info.bxx        = bus.cmt_i_bxx;
  assign info.prdt_taken = bus.cmt_i_prdt_taken;
  assign info.rslv_taken = bus.cmt_i_rslv_taken;

  assign bus.cmt_i_ready = (state_q == ST_IDLE);
  assign beat_acc        = bus.cmt_i_valid & bus.cmt_i_ready;
  assign beat_mis        = beat_acc & is_mispred(info);

  // Fall-through increment for a branch that was predicted taken but not taken.
  assign seq_op2 = {{(PC_W-3){1'b0}}, pc_inc(bus.cmt_i_rv32)};

  // Flush FSM and operand capture; operands stay put until the next mispredict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat_mis) begin
            state_q <= ST_REQ;
            op1_q   <= bus.cmt_i_pc;
            op2_q   <= bus.cmt_i_rslv_taken ? bus.cmt_i_imm : seq_op2;
          end
        end
        ST_REQ: begin
          if (bus.flush_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.flush_req     = (state_q == ST_REQ);
  assign bus.flush_add_op1 = op1_q;
  assign bus.flush_add_op2 = op2_q;

  e203_exu_sat_cnt #(.CNT_W(CNT_W)) u_bjp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (beat_acc & bus.cmt_i_bjp),
    .cnt   (bjp_cnt)
  );

  e203_exu_sat_cnt #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (beat_mis),
    .cnt   (mispred_cnt)
  );

endmodule

// File: tb/tb_e203_exu_bjp_resolver.sv
// Self-checking bench for e203_exu_bjp_resolver: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_e203_exu_bjp_resolver;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cnt_clr;
  logic [CNT_W-1:0] bjp_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  e203_exu_bjp_resolver_if #(.PC_W(PC_W)) bus ();

  e203_exu_bjp_resolver #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cnt_clr     (cnt_clr),
    .bjp_cnt     (bjp_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: a pending-flush flag, the operands it carries and two plain counts.
  bit          m_pending;
  logic [31:0] m_op1, m_op2;
  int          m_bjp, m_mis;

  always @(posedge clk) begin
    bit acc, mis;
    if (!rst_n) begin
      m_pending = 0; m_op1 = 0; m_op2 = 0; m_bjp = 0; m_mis = 0;
    end else begin
      acc = bus.cmt_i_valid && !m_pending;
      mis = acc && bus.cmt_i_bjp && bus.cmt_i_bxx && (bus.cmt_i_prdt_taken != bus.cmt_i_rslv_taken);
      if (cnt_clr) begin
        m_bjp = 0; m_mis = 0;
      end else begin
        if (acc && bus.cmt_i_bjp) m_bjp = (m_bjp < CNT_MAX) ? m_bjp + 1 : CNT_MAX;
        if (mis)                  m_mis = (m_mis < CNT_MAX) ? m_mis + 1 : CNT_MAX;
      end
      if (m_pending) begin
        if (bus.flush_ack) m_pending = 0;
      end else if (mis) begin
        m_pending = 1;
        m_op1 = bus.cmt_i_pc;
        m_op2 = bus.cmt_i_rslv_taken ? bus.cmt_i_imm : (bus.cmt_i_rv32 ? 32'd4 : 32'd2);
      end
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ready",   32'(bus.cmt_i_ready), 32'(!m_pending));
      chk("model_req",     32'(bus.flush_req),   32'(m_pending));
      chk("model_op1",     bus.flush_add_op1,    m_op1);
      chk("model_op2",     bus.flush_add_op2,    m_op2);
      chk("model_bjp",     32'(bjp_cnt),         32'(m_bjp));
      chk("model_mis",     32'(mispred_cnt),     32'(m_mis));
    end
  end

  task automatic idle_inputs();
    bus.cmt_i_valid = 0; bus.cmt_i_bjp = 0; bus.cmt_i_bxx = 0;
    bus.cmt_i_prdt_taken = 0; bus.cmt_i_rslv_taken = 0; bus.cmt_i_rv32 = 1;
    bus.cmt_i_pc = '0; bus.cmt_i_imm = '0; bus.flush_ack = 0; cnt_clr = 0;
  endtask

  // One-cycle commit beat; returns at the negedge after the accepting edge.
  task automatic beat(input logic bjp, input logic bxx, input logic prdt, input logic rslv,
                      input logic rv32, input logic [31:0] pc, input logic [31:0] imm,
                      input logic clr);
    @(negedge clk);
    bus.cmt_i_valid = 1; bus.cmt_i_bjp = bjp; bus.cmt_i_bxx = bxx;
    bus.cmt_i_prdt_taken = prdt; bus.cmt_i_rslv_taken = rslv; bus.cmt_i_rv32 = rv32;
    bus.cmt_i_pc = pc; bus.cmt_i_imm = imm; cnt_clr = clr;
    @(negedge clk);
    bus.cmt_i_valid = 0; cnt_clr = 0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.flush_ack = 1;
    @(negedge clk);
    bus.flush_ack = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.cmt_i_ready), 32'd1);
    chk("rst_req",   32'(bus.flush_req),   32'd0);
    chk("rst_op1",   bus.flush_add_op1,    32'd0);
    chk("rst_bjp",   32'(bjp_cnt),         32'd0);

    // Correct prediction
    beat(1, 1, 1, 1, 1, 32'h100, 32'h40, 0);
    chk("ok_req",   32'(bus.flush_req),   32'd0);
    chk("ok_ready", 32'(bus.cmt_i_ready), 32'd1);
    chk("ok_bjp",   32'(bjp_cnt),         32'd1);
    chk("ok_mis",   32'(mispred_cnt),     32'd0);

    // Taken mispredict, held without ack for 3 cycles
    beat(1, 1, 0, 1, 1, 32'h200, 32'hFFFF_FFF0, 0);
    chk("tk_req", 32'(bus.flush_req),  32'd1);
    chk("tk_op1", bus.flush_add_op1,   32'h200);
    chk("tk_op2", bus.flush_add_op2,   32'hFFFF_FFF0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tk_hold_req",   32'(bus.flush_req),   32'd1);
      chk("tk_hold_op2",   bus.flush_add_op2,    32'hFFFF_FFF0);
      chk("tk_hold_ready", 32'(bus.cmt_i_ready), 32'd0);
    end
    bus.flush_ack = 1;
    #1;
    chk("tk_ack_cycle_ready", 32'(bus.cmt_i_ready), 32'd0);
    @(negedge clk);
    bus.flush_ack = 0;
    chk("tk_after_ready", 32'(bus.cmt_i_ready), 32'd1);
    chk("tk_after_req",   32'(bus.flush_req),   32'd0);
    chk("tk_idle_op1",    bus.flush_add_op1,    32'h200);

    // Not-taken mispredicts, compressed then normal
    beat(1, 1, 1, 0, 0, 32'h300, 32'h80, 0);
    chk("nt16_op1", bus.flush_add_op1, 32'h300);
    chk("nt16_op2", bus.flush_add_op2, 32'd2);
    do_ack();
    beat(1, 1, 1, 0, 1, 32'h300, 32'h80, 0);
    chk("nt32_op2", bus.flush_add_op2, 32'd4);
    do_ack();
    chk("nt_mis", 32'(mispred_cnt), 32'd3);

    // jal and jalr never flush
    beat(1, 0, 1, 1, 1, 32'h400, 32'h10, 0);
    beat(1, 0, 0, 1, 1, 32'h404, 32'h20, 0);
    chk("jal_req", 32'(bus.flush_req), 32'd0);
    chk("jal_bjp", 32'(bjp_cnt),       32'd6);
    chk("jal_mis", 32'(mispred_cnt),   32'd3);

    // Saturation then clear beating a simultaneous increment
    for (int i = 0; i < 20; i++) begin
      beat(1, 1, 0, 1, 1, 32'h500 + 32'(i * 4), 32'h8, 0);
      do_ack();
    end
    chk("sat_mis", 32'(mispred_cnt), 32'd15);
    chk("sat_bjp", 32'(bjp_cnt),     32'd15);
    beat(1, 1, 1, 1, 1, 32'h600, 32'h8, 1);
    chk("clr_bjp", 32'(bjp_cnt),     32'd0);
    chk("clr_mis", 32'(mispred_cnt), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.cmt_i_valid      = 1'($urandom_range(0, 1));
      bus.cmt_i_bjp        = 1'($urandom_range(0, 3) != 0);
      bus.cmt_i_bxx        = 1'($urandom_range(0, 1));
      bus.cmt_i_prdt_taken = 1'($urandom_range(0, 1));
      bus.cmt_i_rslv_taken = 1'($urandom_range(0, 1));
      bus.cmt_i_rv32       = 1'($urandom_range(0, 1));
      bus.cmt_i_pc         = $urandom;
      bus.cmt_i_imm        = $urandom;
      bus.flush_ack        = ($urandom_range(0, 3) == 0);
      cnt_clr              = ($urandom_range(0, 39) == 0);
    end
    idle_inputs();

    // Reset in the middle of an outstanding flush
    do_ack();
    beat(1, 1, 0, 1, 1, 32'h700, 32'h44, 0);
    chk("mid_req_before", 32'(bus.flush_req), 32'd1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_req",   32'(bus.flush_req),   32'd0);
    chk("mid_rst_bjp",   32'(bjp_cnt),         32'd0);
    chk("mid_rst_mis",   32'(mispred_cnt),     32'd0);
    chk("mid_rst_op1",   bus.flush_add_op1,    32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(bus.cmt_i_ready), 32'd1);
    repeat (2) @(negedge clk);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
